// File: rtl/sram_1rw_nr_param.sv
// Single read/write port SRAM with NUM_RPORTS extra read-only ports, self-clearing after reset.
// Optional macro SRAM_RDW_BYPASS_EN: colliding read-port reads see the write-through word.
module sram_1rw_nr_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4,
  parameter int NUM_RPORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [NUM_WMASKS-1:0]            wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dout0_valid,
  input  logic [NUM_RPORTS-1:0]            csb_r,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr_r,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout_r,
  output logic [NUM_RPORTS-1:0]            dout_r_valid,
  output logic                             ready,
  output logic [15:0]                      coll_cnt
);

  localparam int RAM_DEPTH = 2**ADDR_WIDTH;
  localparam int LANE_W    = DATA_WIDTH / NUM_WMASKS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   sweep;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_en;
  logic                  rd0_en;
  logic [NUM_RPORTS-1:0] rd_en;
  logic [NUM_RPORTS-1:0] coll;
  logic [DATA_WIDTH-1:0] rd_word [NUM_RPORTS];

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int l = 0; l < NUM_WMASKS; l++) begin
      if (mask[l]) res[l*LANE_W +: LANE_W] = new_word[l*LANE_W +: LANE_W];
    end
    return res;
  endfunction

  assign wr_en  = (state == RUN) && !csb0 && !web0;
  assign rd0_en = (state == RUN) && !csb0 && web0;

  always_comb begin
    rd_en = '0;
    coll  = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rd_en[i]   = (state == RUN) && !csb_r[i];
      coll[i]    = wr_en && rd_en[i] && (addr_r[i*ADDR_WIDTH +: ADDR_WIDTH] == addr0);
      rd_word[i] = mem[addr_r[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef SRAM_RDW_BYPASS_EN
      if (coll[i]) rd_word[i] = merge_lanes(rd_word[i], din0, wmask0);
`endif
    end
  end

  // Storage: written only by the clearing sweep or by port-0 writes, never by reset itself
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        if (!sweep[ADDR_WIDTH]) mem[sweep[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_en) begin
        mem[addr0] <= merge_lanes(mem[addr0], din0, wmask0);
      end
    end
  end

  // Control and read registers; sweep overruns to RAM_DEPTH, giving one extra INIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      sweep        <= '0;
      ready        <= 1'b0;
      dout0        <= '0;
      dout0_valid  <= 1'b0;
      dout_r       <= '0;
      dout_r_valid <= '0;
      coll_cnt     <= '0;
    end else begin
      dout0_valid  <= 1'b0;
      dout_r_valid <= '0;
      case (state)
        INIT: begin
          if (sweep[ADDR_WIDTH]) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        RUN: begin
          if (rd0_en) begin
            dout0       <= mem[addr0];
            dout0_valid <= 1'b1;
          end
          for (int i = 0; i < NUM_RPORTS; i++) begin
            if (rd_en[i]) begin
              dout_r[i*DATA_WIDTH +: DATA_WIDTH] <= rd_word[i];
              dout_r_valid[i]                    <= 1'b1;
            end
          end
          if ((|coll) && (coll_cnt != 16'hFFFF)) coll_cnt <= coll_cnt + 16'd1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1rw_nr_param.sv
// Scoreboard bench for sram_1rw_nr_param at default parameters (512 x 32, 2 read ports).
module tb_sram_1rw_nr_param;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [8:0]  addr0 = '0;
  logic [31:0] din0 = '0;
  logic [31:0] dout0;
  logic        dout0_valid;
  logic [1:0]  csb_r = 2'b11;
  logic [17:0] addr_r = '0;
  logic [63:0] dout_r;
  logic [1:0]  dout_r_valid;
  logic        ready;
  logic [15:0] coll_cnt;

  sram_1rw_nr_param dut (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0), .dout0_valid(dout0_valid),
    .csb_r(csb_r), .addr_r(addr_r), .dout_r(dout_r), .dout_r_valid(dout_r_valid),
    .ready(ready), .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp0_q [$];
  logic [31:0] exp_r0_q [$];
  logic [31:0] exp_r1_q [$];
  logic [15:0] exp_coll;
  logic [31:0] last_rd0;

  function automatic logic [31:0] wt(input logic [31:0] old_w, input logic [31:0] new_w,
                                     input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (new_w & bm) | (old_w & ~bm);
  endfunction

  function automatic logic [31:0] coll_read(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] m);
`ifdef SRAM_RDW_BYPASS_EN
    return wt(old_w, new_w, m);
`else
    return old_w;
`endif
  endfunction

  // Output monitor: every valid pops one expected word
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (dout0_valid === 1'b1) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++; $display("FAIL dout0_unexpected_valid: dout0=%h, no read outstanding", dout0);
      end else begin
        e = exp0_q.pop_front();
        if (dout0 !== e) begin errors++; $display("FAIL dout0_data: got %h expected %h", dout0, e); end
      end
    end
    if (dout_r_valid[0] === 1'b1) begin
      checks++;
      if (exp_r0_q.size() == 0) begin
        errors++; $display("FAIL rport0_unexpected_valid: data=%h, no read outstanding", dout_r[31:0]);
      end else begin
        e = exp_r0_q.pop_front();
        if (dout_r[31:0] !== e) begin errors++; $display("FAIL rport0_data: got %h expected %h", dout_r[31:0], e); end
      end
    end
    if (dout_r_valid[1] === 1'b1) begin
      checks++;
      if (exp_r1_q.size() == 0) begin
        errors++; $display("FAIL rport1_unexpected_valid: data=%h, no read outstanding", dout_r[63:32]);
      end else begin
        e = exp_r1_q.pop_front();
        if (dout_r[63:32] !== e) begin errors++; $display("FAIL rport1_data: got %h expected %h", dout_r[63:32], e); end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; csb_r = 2'b11;
  endtask

  task automatic clear_model();
    foreach (model[i]) model[i] = '0;
    exp_coll = '0;
    last_rd0 = '0;
  endtask

  task automatic wait_ready(input bit inject, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
      if (inject) begin
        if (cycles == 1) begin
          csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h1FF;
          csb_r = 2'b00; addr_r = {9'h004, 9'h003};
        end
        if (cycles == 100) idle();
        if (cycles == 300) begin
          csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'h005; din0 = 32'hFFFF_FFFF;
        end
        if (cycles == 310) idle();
      end
    end while (ready !== 1'b1 && cycles < 2000);
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp0_q.size() != 0 || exp_r0_q.size() != 0 || exp_r1_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: outstanding p0=%0d r0=%0d r1=%0d required 0", tag,
               exp0_q.size(), exp_r0_q.size(), exp_r1_q.size());
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1; idle();
    step(); step();
    checks++;
    if (ready !== 1'b0 || dout0 !== '0 || dout0_valid !== 1'b0) begin
      errors++; $display("FAIL reset_p0: ready=%b dout0=%h valid=%b required 0/0/0", ready, dout0, dout0_valid);
    end
    checks++;
    if (dout_r !== '0 || dout_r_valid !== 2'b00 || coll_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_rports: dout_r=%h valid=%b coll=%h required 0", dout_r, dout_r_valid, coll_cnt);
    end
    clear_model();
    rst = 1'b0;
    wait_ready(1'b1, cyc);
    checks++;
    if (cyc != DEPTH + 1) begin errors++; $display("FAIL init_latency: ready after %0d cycles required %0d", cyc, DEPTH + 1); end
    // read the last cleared word on port 0 and the INIT-time write target on read port 0
    csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h1FF; exp0_q.push_back(32'h0); last_rd0 = 32'h0;
    csb_r = 2'b10; addr_r[8:0] = 9'h005; exp_r0_q.push_back(32'h0);
    step(); idle(); step();
    check_drained("reset");
    checks++;
    if (coll_cnt !== 16'h0) begin errors++; $display("FAIL init_coll: coll_cnt=%h required 0000", coll_cnt); end
  endtask

  task automatic test_mask_write();
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'h010; din0 = 32'hDEAD_BEEF;
    model[9'h010] = wt(model[9'h010], din0, wmask0);
    step();
    wmask0 = 4'h1; din0 = 32'h0000_00AA;
    model[9'h010] = wt(model[9'h010], din0, wmask0);
    step();
    checks++;
    if (dout0 !== last_rd0 || dout0_valid !== 1'b0) begin
      errors++; $display("FAIL write_holds_dout0: dout0=%h valid=%b required %h/0", dout0, dout0_valid, last_rd0);
    end
    web0 = 1'b1; exp0_q.push_back(32'hDEAD_BEAA); last_rd0 = 32'hDEAD_BEAA;
    step();
    checks++;
    if (dout0_valid !== 1'b1) begin errors++; $display("FAIL rd0_valid_high: valid=%b required 1", dout0_valid); end
    idle(); step();
    checks++;
    if (dout0_valid !== 1'b0 || dout0 !== 32'hDEAD_BEAA) begin
      errors++; $display("FAIL rd0_valid_pulse: valid=%b dout0=%h required 0/deadbeaa", dout0_valid, dout0);
    end
    check_drained("mask");
  endtask

  task automatic test_collision();
    logic [31:0] old_w;
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'h020; din0 = 32'h1234_5678;
    csb_r = 2'b01; addr_r[17:9] = 9'h020;
`ifdef SRAM_RDW_BYPASS_EN
    exp_r1_q.push_back(32'h1234_5678);
`else
    exp_r1_q.push_back(32'h0000_0000);
`endif
    model[9'h020] = wt(model[9'h020], din0, wmask0);
    step(); idle();
    checks++;
    if (coll_cnt !== 16'd1) begin errors++; $display("FAIL coll_single: coll_cnt=%h required 0001", coll_cnt); end
    // two read ports hitting a partial-mask write count once
    old_w = model[9'h020];
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0101; din0 = 32'hAABB_CCDD;
    csb_r = 2'b00; addr_r = {9'h020, 9'h020};
    exp_r0_q.push_back(coll_read(old_w, din0, wmask0));
    exp_r1_q.push_back(coll_read(old_w, din0, wmask0));
    model[9'h020] = wt(old_w, din0, wmask0);
    step(); idle();
    checks++;
    if (coll_cnt !== 16'd2) begin errors++; $display("FAIL coll_dual: coll_cnt=%h required 0002", coll_cnt); end
    csb_r = 2'b10; addr_r[8:0] = 9'h020; exp_r0_q.push_back(32'h12BB_56DD);
    step(); idle(); step();
    exp_coll = 16'd2;
    check_drained("coll");
  endtask

  task automatic test_back_to_back();
    int          op;
    logic [8:0]  a0, ra0, ra1;
    logic        en0, en1, any_coll;
    logic [31:0] e;
    csb_r = 2'b00; addr_r = {9'h020, 9'h010};
    exp_r0_q.push_back(model[9'h010]); exp_r1_q.push_back(model[9'h020]);
    step(); idle();
    checks++;
    if (dout_r_valid !== 2'b11) begin errors++; $display("FAIL dual_read_valid: valid=%b required 11", dout_r_valid); end
    for (int n = 0; n < 200; n++) begin
      op  = int'($urandom_range(0, 2));
      a0  = 9'h040 + 9'($urandom_range(0, 7));
      ra0 = 9'h040 + 9'($urandom_range(0, 7));
      ra1 = 9'h040 + 9'($urandom_range(0, 7));
      en0 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
      csb0 = (op == 0); web0 = (op != 1); addr0 = a0;
      din0 = $urandom; wmask0 = 4'($urandom_range(0, 15));
      csb_r = {~en1, ~en0}; addr_r = {ra1, ra0};
      any_coll = 1'b0;
      if (en0) begin
        if (op == 1 && ra0 == a0) begin any_coll = 1'b1; e = coll_read(model[ra0], din0, wmask0); end
        else e = model[ra0];
        exp_r0_q.push_back(e);
      end
      if (en1) begin
        if (op == 1 && ra1 == a0) begin any_coll = 1'b1; e = coll_read(model[ra1], din0, wmask0); end
        else e = model[ra1];
        exp_r1_q.push_back(e);
      end
      if (op == 2) begin exp0_q.push_back(model[a0]); last_rd0 = model[a0]; end
      if (op == 1) model[a0] = wt(model[a0], din0, wmask0);
      if (any_coll && exp_coll != 16'hFFFF) exp_coll = exp_coll + 16'd1;
      step();
      checks++;
      if (coll_cnt !== exp_coll) begin errors++; $display("FAIL rand_coll_cnt: got %h expected %h at n=%0d", coll_cnt, exp_coll, n); end
      if (op == 1) begin
        checks++;
        if (dout0 !== last_rd0 || dout0_valid !== 1'b0) begin
          errors++; $display("FAIL rand_write_hold: dout0=%h valid=%b required %h/0", dout0, dout0_valid, last_rd0);
        end
      end
    end
    idle(); step(); step();
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_init();
    int cyc;
    rst = 1'b1; idle(); step();
    rst = 1'b0;
    repeat (256) step();
    rst = 1'b1; step();
    checks++;
    if (ready !== 1'b0 || coll_cnt !== 16'h0) begin
      errors++; $display("FAIL mid_init_reset: ready=%b coll=%h required 0/0000", ready, coll_cnt);
    end
    clear_model();
    rst = 1'b0;
    wait_ready(1'b0, cyc);
    checks++;
    if (cyc != DEPTH + 1) begin errors++; $display("FAIL mid_init_latency: ready after %0d cycles required %0d", cyc, DEPTH + 1); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h010; exp0_q.push_back(32'h0);
    csb_r = 2'b00; addr_r = {9'h044, 9'h020}; exp_r0_q.push_back(32'h0); exp_r1_q.push_back(32'h0);
    step(); idle(); step();
    check_drained("mid_init");
  endtask

  task automatic test_saturation();
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'h030; din0 = 32'h0;
    csb_r = 2'b10; addr_r[8:0] = 9'h030;
    for (int i = 0; i < 65540; i++) begin
      exp_r0_q.push_back(32'h0);
      step();
      if (i == 65533) begin
        checks++;
        if (coll_cnt !== 16'hFFFE) begin errors++; $display("FAIL coll_near_sat: got %h expected fffe", coll_cnt); end
      end
    end
    idle();
    checks++;
    if (coll_cnt !== 16'hFFFF) begin errors++; $display("FAIL coll_saturate: got %h expected ffff", coll_cnt); end
    step(); step();
    check_drained("sat");
  endtask

  initial begin
    test_reset();
    test_mask_write();
    test_collision();
    test_back_to_back();
    test_reset_mid_init();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
